// File: rtl/display_scan_driver.sv
// Multiplexed six-digit display scanner: snapshots all digit bytes and flags once per
// frame, then drives one digit at a time with optional all-off blanking between digits.
module display_scan_driver #(
    parameter int DWELL = 64,
    parameter int BLANK = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] upper10,
    input  logic [7:0] upper01,
    input  logic [7:0] lower1000,
    input  logic [7:0] lower0100,
    input  logic [7:0] lower0010,
    input  logic [7:0] lower0001,
    input  logic       AVS,
    input  logic       DAY,
    input  logic       MAX,
    input  logic       TIM,
    input  logic       col,
    input  logic       point,
    output logic [7:0] seg,
    output logic [5:0] dig,
    output logic [5:0] ann,
    output logic       frame_start
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHOW, S_BLANK} state_t;

    localparam logic [9:0] DWELL_M1 = 10'(DWELL - 1);
    localparam logic [9:0] BLANK_M1 = (BLANK == 0) ? 10'd0 : 10'(BLANK - 1);

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [9:0]      r_cnt, w_cnt_nxt;
    logic            r_ann_vld, w_ann_vld_nxt;
    logic [5:0][7:0] r_shadow;
    logic [5:0]      r_flags;
    logic            w_slot_end;
    logic [7:0]      w_cur_byte;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= 3'd0;
            r_cnt     <= 10'd0;
            r_ann_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ann_vld <= w_ann_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_ann_vld_nxt = r_ann_vld;
        w_slot_end    = 1'b0;
        case (r_state)
            S_IDLE: if (en) w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_state_nxt   = S_SHOW;
                w_idx_nxt     = 3'd0;
                w_cnt_nxt     = DWELL_M1;
                w_ann_vld_nxt = 1'b1;
            end
            S_SHOW: begin
                if (r_cnt != 10'd0) begin
                    w_cnt_nxt = r_cnt - 10'd1;
                end else if (BLANK > 0) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = BLANK_M1;
                end else begin
                    w_slot_end = 1'b1;
                end
            end
            S_BLANK: begin
                if (r_cnt != 10'd0) w_cnt_nxt = r_cnt - 10'd1;
                else                w_slot_end = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // en is only honoured once the sixth digit has finished, so frames never truncate
        if (w_slot_end) begin
            if (r_idx != 3'd5) begin
                w_state_nxt = S_SHOW;
                w_idx_nxt   = r_idx + 3'd1;
                w_cnt_nxt   = DWELL_M1;
            end else if (en) begin
                w_state_nxt = S_LOAD;
                w_cnt_nxt   = 10'd0;
            end else begin
                w_state_nxt   = S_IDLE;
                w_cnt_nxt     = 10'd0;
                w_ann_vld_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shadow <= '0;
            r_flags  <= '0;
        end else if (r_state == S_LOAD) begin
            r_shadow <= {lower0001, lower0010, lower0100, lower1000, upper01, upper10};
            r_flags  <= {point, col, TIM, MAX, DAY, AVS};
        end
    end

    always_comb begin
        case (r_idx)
            3'd0:    w_cur_byte = r_shadow[0];
            3'd1:    w_cur_byte = r_shadow[1];
            3'd2:    w_cur_byte = r_shadow[2];
            3'd3:    w_cur_byte = r_shadow[3];
            3'd4:    w_cur_byte = r_shadow[4];
            3'd5:    w_cur_byte = r_shadow[5];
            default: w_cur_byte = 8'd0;
        endcase
    end

    // Outputs decode from registers only; async reset therefore clears them immediately
    always_comb begin
        seg         = 8'd0;
        dig         = 6'd0;
        ann         = r_ann_vld ? r_flags : 6'd0;
        frame_start = (r_state == S_LOAD);
        if (r_state == S_SHOW) begin
            dig = 6'b000001 << r_idx;
            seg = w_cur_byte;
        end
    end

endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Multiplexed display driver that reads the six digit bytes and six annunciator flags produced by the bicycle-computer control block and drives one shared 8-bit segment bus, one digit at a time. Each frame starts with a snapshot of every input, so a value that changes mid-scan never appears partly updated on the glass. Non-overlap blanking between digits prevents ghosting. The block sits between the top-level display outputs and the physical LCD/LED pins.

## Interface
- DWELL, 64: clock cycles each digit is driven; legal range 1..1023.
- BLANK, 4: clock cycles with all digits off between consecutive digits; legal range 0..1023. A value of 0 skips the BLANK state.
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  scan enable, sampled only in IDLE and at the end of a frame.
- upper10, upper01, lower1000, lower0100, lower0010, lower0001  input  8 each  segment bytes, bit 7 = dp.
- AVS, DAY, MAX, TIM, col, point  input  1 each  annunciator flags.
- seg  output  8  segment bus, active-high.
- dig  output  6  one-hot digit enable, active-high. dig[0]=upper10, dig[1]=upper01, dig[2]=lower1000, dig[3]=lower0100, dig[4]=lower0010, dig[5]=lower0001.
- ann  output  6  latched flags {point,col,TIM,MAX,DAY,AVS}, with bit 0 = AVS.
- frame_start  output  1  one-cycle pulse during the LOAD state.

## Operation
- State machine states: IDLE, LOAD, SHOW, BLANK. Registers: 2-bit state, 3-bit digit index idx (0..5), 10-bit dwell counter, six 8-bit byte shadows, 6-bit flag shadow.
- All outputs decode from registers only. There is no combinational path from any input to any output.
- IDLE: seg=0, dig=0, ann=0. If en=1, go to LOAD.
- LOAD: lasts exactly 1 cycle; frame_start=1; seg=0, dig=0. At the closing edge: capture all six bytes and six flags into the shadows, set idx=0, load the counter. Next state is SHOW.
- SHOW: dig = one-hot(idx); seg = shadow[idx]; ann = flag shadow. Lasts DWELL cycles. After that, go to BLANK, or, if BLANK=0, take the end-of-slot transition directly.
- BLANK: dig=0, seg=0, ann held. Lasts BLANK cycles.
- End-of-slot transition:
  - idx<5: idx+1, then SHOW.
  - idx=5 and en=1: LOAD.
  - idx=5 and en=0: IDLE.
- en falling mid-frame: the frame completes all six digits, then the block goes to IDLE. There is no truncation.
- Input changes during SHOW or BLANK have no effect until the next LOAD.
- Shadow registers are written only in LOAD.
- Counter: loads DWELL-1 (or BLANK-1) on state entry and decrements. The state exits on the cycle the counter reads 0.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, idx=0, counter=0, shadows=0, seg=0, dig=0, ann=0, frame_start=0. Deassertion is synchronised by the integrator; the block must tolerate release at any edge.
- Reset asserted mid-frame: all outputs drop to 0 immediately, without waiting for a clock edge.
- Start-up: en sampled 1 in IDLE at edge N gives LOAD (frame_start=1) in cycle N+1 and dig[0] high from cycle N+2.
- Frame period with en held high: 1 + 6·(DWELL+BLANK) cycles. Defaults give 409 cycles. frame_start pulses repeat exactly at this period.
- dig is never multi-hot.
- With BLANK≥1 there is at least one all-zero dig cycle between two different active digits.
- With BLANK=0, dig[k] falls and dig[k+1] rises on the same edge.
- ann updates only in the first SHOW cycle of a frame. It is cleared on entry to IDLE.

## Test plan
- Reset values: hold reset=0 with en=1 and random inputs -> seg=0, dig=0, ann=0, frame_start=0 on every cycle.
- Basic frame, defaults: bytes 0x06,0x5B,0x4F,0x66,0x6D,0x7D with AVS=1, others 0; release reset, en=1 -> frame_start pulse, then dig=000001/seg=0x06 for 64 cycles, 4 blank cycles, and so on through dig=100000/seg=0x7D; ann=000001; next frame_start 409 cycles after the first.
- No tearing: change lower0001 to 0xFF at cycle 100 of a frame -> dig[5] slot still shows the old value; 0xFF appears only in the following frame.
- en drop: deassert en while dig[2] is active -> digits 2..5 complete, then IDLE with seg=dig=ann=0 and no further frame_start; reassert en -> frame_start one cycle later.
- BLANK=0, DWELL=1: continuous en -> dig steps every cycle; frame period 7 cycles; dig is never zero except during the LOAD cycle.
- Reset mid-operation: assert reset during SHOW of idx=3 -> outputs zero asynchronously; after release with en=1, the frame restarts at LOAD and idx=0.
